// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command initiator.
//   - FSM state encoding (kept as plain 2-bit constants so older tools and
//     waveform viewers see stable numeric values)
//   - response error codes carried on rsp_err_o
//   - default bounded-wait limit and counter width
package wb_cmd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic RSP_ERR_NONE    = 1'b0;
    localparam logic RSP_ERR_TIMEOUT = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/wb_cmd_initiator_timeout_ctr.sv
// wb_timeout_ctr: saturating wait counter for bus initiators.
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset (counter to 0)
//   clr_i      synchronous clear, wins over en_i
//   en_i       count one more waited cycle
//   expired_o  high while the count equals LIMIT-1 (never high if LIMIT = 0)
// The count sticks at all-ones instead of wrapping, so a long wait with
// LIMIT = 0 can never alias back into a small value.
module wb_timeout_ctr #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// wb_cmd_initiator: single-outstanding Wishbone classic initiator.
//   Command side  : cmd_valid_i/cmd_ready_o with adr/dat/sel/we
//   Response side : rsp_valid_o/rsp_ready_i with rsp_dat_o/rsp_err_o
//   Bus side      : wb_cyc_o = wb_stb_o, wb_we_o/adr/dat/sel registered,
//                   wb_dat_i/wb_ack_i (ack may be combinational from STB)
//   busy_o        : high whenever a command is in flight (BUS or RESP)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload stable until taken.
// A bus cycle that sees no ACK for TIMEOUT cycles ends with rsp_err_o = 1.
module wb_cmd_initiator
    import wb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic        cmd_we_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o
);

    logic [1:0]  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    logic cmd_hs;
    logic tmo_expired;

    // Ready is gated by reset so that no command can appear accepted in a
    // cycle whose edge is going to reset the FSM anyway.
    assign cmd_ready_o = (state_q == ST_IDLE) && !wb_rst_i;
    assign cmd_hs      = cmd_valid_i && cmd_ready_o;

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_timeout_ctr (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (cmd_hs),
        .en_i      ((state_q == ST_BUS) && !wb_ack_i),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    we_d    = cmd_we_i;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // ACK is checked first so a responder answering in the very
                // cycle the wait expires still delivers its data.
                if (wb_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wb_dat_i;
                    rsp_err_d = RSP_ERR_NONE;
                    state_d   = ST_RESP;
                end else if (tmo_expired) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = RSP_ERR_TIMEOUT;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign wb_cyc_o    = (state_q == ST_BUS);
    assign wb_stb_o    = (state_q == ST_BUS);
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Bench for wb_cmd_initiator with a counter-timer style responder at
// 0x2400_0000 (three registers, same-cycle ACK), an unmapped hole and a
// "late" address that ACKs only on the last allowed STB cycle.
module tb_wb_cmd_initiator;

    localparam int          TMO      = 4;
    localparam logic [31:0] BASE     = 32'h2400_0000;
    localparam logic [31:0] UNMAP    = 32'h2400_0010;
    localparam logic [31:0] LATE     = 32'h2400_0020;
    localparam logic [31:0] LATE_DAT = 32'hCAFE_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_we = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        busy_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;

    int rdy_mode = 1;      // 0: hold rsp_ready low, 1: tied high, 2: random
    bit spur_en = 1'b0;
    logic spur = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_initiator #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .cmd_we_i    (cmd_we),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .busy_o      (busy_o)
    );

    function automatic int reg_idx(input logic [31:0] a);
        if (a == BASE)          return 0;
        if (a == BASE + 32'h4)  return 1;
        if (a == BASE + 32'h8)  return 2;
        return -1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // ---------------- responder ----------------
    logic [31:0] regs [3];
    int stb_run = 0;
    int r_idx;

    initial for (int i = 0; i < 3; i++) regs[i] = 32'h0;

    always @(posedge clk) begin
        if (wb_stb_o) stb_run <= stb_run + 1;
        else          stb_run <= 0;
        if (wb_stb_o && wb_ack_i && wb_we_o && reg_idx(wb_adr_o) >= 0)
            regs[reg_idx(wb_adr_o)] <= merge(regs[reg_idx(wb_adr_o)], wb_dat_o, wb_sel_o);
    end

    always_comb begin
        r_idx    = reg_idx(wb_adr_o);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hDEAD_BEEF;
        if (wb_stb_o) begin
            wb_ack_i = (r_idx >= 0) || ((wb_adr_o == LATE) && (stb_run == TMO - 1));
            if (r_idx >= 0)            wb_dat_i = regs[r_idx];
            else if (wb_adr_o == LATE) wb_dat_i = LATE_DAT;
        end else begin
            wb_ack_i = spur;   // stray ACKs outside a cycle must be ignored
        end
    end

    // Response-side and stray-ACK stimulus, applied just after each edge.
    always @(posedge clk) begin
        #2;
        if (rdy_mode == 2) rsp_ready = 1'($urandom_range(0, 1));
        else               rsp_ready = (rdy_mode == 1);
        spur = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // ---------------- reference model + compare ----------------
    // Per accepted command the model predicts the STB length, the response
    // and its arrival cycle; all outputs are then checked every cycle.
    logic [31:0] exp_mem [3];
    bit          outst = 1'b0;
    int          hs_cyc = 0, last_hs = 0, prev_hs = 0;
    int          c_len = 0;
    logic [31:0] c_rdat = '0;
    logic        c_rerr = 1'b0;
    logic [31:0] l_adr = '0, l_dat = '0;
    logic [3:0]  l_sel = '0;
    logic        l_we = 1'b0;
    int          n_rsp = 0, stb_total = 0;
    logic [31:0] last_rsp_dat = '0;
    logic        last_rsp_err = 1'b0;

    initial for (int i = 0; i < 3; i++) exp_mem[i] = 32'h0;

    always @(negedge clk) begin
        int d;
        int idx;
        if (rst) begin
            chk("rst_cmd_ready", cmd_ready_o, 0);
            outst = 1'b0;
            l_adr = '0; l_dat = '0; l_sel = '0; l_we = 1'b0;
        end else begin
            chk("cmd_ready", cmd_ready_o, !outst);
            chk("busy", busy_o, outst);
            chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            chk("wb_adr", wb_adr_o, l_adr);
            chk("wb_dat", wb_dat_o, l_dat);
            chk("wb_sel", wb_sel_o, l_sel);
            chk("wb_we", wb_we_o, l_we);
            if (wb_stb_o) stb_total++;
            if (outst) begin
                d = cyc_n - hs_cyc;
                chk("stb_window", wb_stb_o, (d >= 1) && (d <= c_len));
                chk("rsp_valid_window", rsp_valid_o, d > c_len);
                if (rsp_valid_o) begin
                    chk("rsp_dat", rsp_dat_o, c_rdat);
                    chk("rsp_err", rsp_err_o, c_rerr);
                end
            end else begin
                chk("idle_stb", wb_stb_o, 0);
                chk("idle_rsp_valid", rsp_valid_o, 0);
            end
            if (outst && rsp_valid_o && rsp_ready) begin
                outst = 1'b0;
                n_rsp++;
                last_rsp_dat = rsp_dat_o;
                last_rsp_err = rsp_err_o;
            end else if (!outst && cmd_valid && cmd_ready_o) begin
                idx = reg_idx(cmd_adr);
                if (idx >= 0) begin
                    c_len  = 1;
                    c_rerr = 1'b0;
                    c_rdat = cmd_we ? 32'h0 : exp_mem[idx];
                    if (cmd_we) exp_mem[idx] = merge(exp_mem[idx], cmd_dat, cmd_sel);
                end else if (cmd_adr == LATE) begin
                    c_len  = TMO;
                    c_rerr = 1'b0;
                    c_rdat = cmd_we ? 32'h0 : LATE_DAT;
                end else begin
                    c_len  = TMO;
                    c_rerr = 1'b1;
                    c_rdat = 32'h0;
                end
                outst   = 1'b1;
                hs_cyc  = cyc_n;
                prev_hs = last_hs;
                last_hs = cyc_n;
                l_adr = cmd_adr; l_dat = cmd_dat; l_sel = cmd_sel; l_we = cmd_we;
            end
        end
        cyc_n++;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s,
                        input logic w);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_adr = a; cmd_dat = dv; cmd_sel = s; cmd_we = w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // Garbage on the idle command bus must not leak into the cycle.
        cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom); cmd_we = 1'($urandom);
        chk("send_bound", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!outst && cmd_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        chk("idle_bound", ok, 1);
    endtask

    initial begin
        int s0, r0;
        logic [31:0] ra;
        // reset
        rst = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("reset_cyc", wb_cyc_o, 0);
        chk("reset_adr", wb_adr_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_busy", busy_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready_o, 1);
        chk("post_reset_rsp_dat", rsp_dat_o, 0);
        chk("post_reset_rsp_err", rsp_err_o, 0);
        @(posedge clk); #1;

        // 1: write VALUE then read it back
        s0 = stb_total;
        send(BASE + 32'h4, 32'h0000_1234, 4'hF, 1'b1);
        wait_idle();
        chk("t1_stb_cycles", stb_total - s0, 1);
        chk("t1_wr_err", last_rsp_err, 0);
        chk("t1_wr_dat", last_rsp_dat, 0);
        send(BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        wait_idle();
        chk("t1_rd_dat", last_rsp_dat, 32'h0000_1234);

        // 2: back-to-back write/read of CONFIG, 3-cycle spacing
        send(BASE, 32'h11, 4'hF, 1'b1);
        send(BASE, 32'h0, 4'hF, 1'b0);
        wait_idle();
        chk("t2_spacing", last_hs - prev_hs, 3);
        chk("t2_cfg_rd", last_rsp_dat, 32'h0000_0011);

        // 3: unmapped read times out after exactly TMO strobe cycles
        s0 = stb_total;
        send(UNMAP, 32'h0, 4'hF, 1'b0);
        wait_idle();
        chk("t3_stb_cycles", stb_total - s0, TMO);
        chk("t3_err", last_rsp_err, 1);
        chk("t3_dat", last_rsp_dat, 0);
        send(BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        wait_idle();
        chk("t3_next_rd", last_rsp_dat, 32'h0000_1234);
        chk("t3_next_err", last_rsp_err, 0);

        // 4: response backpressure
        rdy_mode = 0;
        send(BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        cycles(12);
        @(negedge clk);
        chk("t4_rsp_valid", rsp_valid_o, 1);
        chk("t4_rsp_dat", rsp_dat_o, 32'h0000_1234);
        chk("t4_cmd_ready", cmd_ready_o, 0);
        chk("t4_cyc", wb_cyc_o, 0);
        @(posedge clk); #1;
        rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_release_ready", cmd_ready_o, 1);
        @(posedge clk); #1;

        // 5: reset in the middle of a timing-out cycle
        r0 = n_rsp;
        send(UNMAP, 32'h0, 4'hF, 1'b0);
        cycles(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_cyc", wb_cyc_o, 0);
        chk("t5_stb", wb_stb_o, 0);
        chk("t5_rsp_valid", rsp_valid_o, 0);
        chk("t5_ready", cmd_ready_o, 1);
        cycles(10);
        chk("t5_no_rsp", n_rsp, r0);

        // 6: ACK on the last allowed cycle beats the timeout
        s0 = stb_total;
        send(LATE, 32'h0, 4'hF, 1'b0);
        wait_idle();
        chk("t6_stb_cycles", stb_total - s0, TMO);
        chk("t6_err", last_rsp_err, 0);
        chk("t6_dat", last_rsp_dat, LATE_DAT);

        // random traffic with random backpressure and stray ACKs
        rdy_mode = 2;
        spur_en  = 1'b1;
        r0 = n_rsp;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 4))
                0: ra = BASE;
                1: ra = BASE + 32'h4;
                2: ra = BASE + 32'h8;
                3: ra = UNMAP;
                default: ra = LATE;
            endcase
            send(ra, $urandom, 4'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) cycles($urandom_range(0, 3));
        end
        wait_idle();
        chk("rand_rsp_count", n_rsp - r0, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
